// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter.
// Optional starvation guard is enabled by defining WB_ARB_STARVE_GUARD_EN.
package wb_arb_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic                  rf_en;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    FORCE
  } wb_arb_state_t;

endpackage

// File: rtl/wb_arbiter_hold_buf.sv
// One-entry holding buffer for an MDU result waiting for the register-file port.
module wb_hold_buf
  import wb_arb_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [REG_AW-1:0] load_rd,
  input  logic [XLEN-1:0]   load_data,
  input  logic              drain,
  input  logic              kill,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   data
);

  // Loads only happen while empty, so they never collide with drain or kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else begin
      if (drain || kill) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      if (load) begin
        rd   <= load_rd;
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between write-back and a buffered MDU result.
// Define WB_ARB_STARVE_GUARD_EN to add the wait counter and one-cycle FORCE drain.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int REG_AW       = DEF_REG_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_rf_en,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_wdata,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_wdata,
  output logic              mdu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              buf_valid,
  output logic [REG_AW-1:0] buf_rd
);

  wb_arb_state_t   state, state_nxt;
  wb_req_t         grant;
  logic            pipe_act, force_now, buf_load, buf_drain, buf_kill;
  logic [XLEN-1:0] buf_data;

  assign pipe_act  = pipe_rf_en && (pipe_rd != '0);
  assign mdu_ready = rst_n && !buf_valid;
  assign buf_load  = mdu_valid && mdu_ready && (mdu_rd != '0);

`ifdef WB_ARB_STARVE_GUARD_EN
  assign force_now = (state == FORCE);
`else
  assign force_now = 1'b0;
`endif
  assign pipe_stall = force_now;

  wb_hold_buf #(.XLEN(XLEN), .REG_AW(REG_AW)) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_rd   (mdu_rd),
    .load_data (mdu_wdata),
    .drain     (buf_drain),
    .kill      (buf_kill),
    .valid     (buf_valid),
    .rd        (buf_rd),
    .data      (buf_data)
  );

  // A same-register pipeline write is younger, so it kills the buffered result.
  always_comb begin
    grant     = '0;
    buf_drain = 1'b0;
    buf_kill  = 1'b0;
    if (force_now) begin
      grant     = '{rf_en: 1'b1, rd: buf_rd, data: buf_data};
      buf_drain = 1'b1;
    end else if (pipe_act) begin
      grant    = '{rf_en: 1'b1, rd: pipe_rd, data: pipe_wdata};
      buf_kill = buf_valid && (pipe_rd == buf_rd);
    end else if (buf_valid) begin
      grant     = '{rf_en: 1'b1, rd: buf_rd, data: buf_data};
      buf_drain = 1'b1;
    end
  end

  assign rf_we    = rst_n && grant.rf_en;
  assign rf_waddr = rst_n ? grant.rd : '0;
  assign rf_wdata = rst_n ? grant.data : '0;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  // Counts HELD cycles that end without the port; FORCE follows the last one.
  always_comb begin
    wait_cnt_nxt = '0;
    if (state == HELD && state_nxt == HELD) begin
      wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (buf_load) state_nxt = HELD;
      HELD: begin
        if (buf_drain || buf_kill) begin
          state_nxt = EMPTY;
`ifdef WB_ARB_STARVE_GUARD_EN
        end else if (wait_cnt >= CNT_LAST) begin
          state_nxt = FORCE;
`endif
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus contention sequences.
// The contention sequence follows WB_ARB_STARVE_GUARD_EN (forced drain vs. indefinite wait).
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_rf_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        buf_valid;
  logic [4:0]  buf_rd;

  typedef struct {
    logic        rst_n;
    logic        pen;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_rdy;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_bv;
    logic [4:0]  e_brd;
  } vec_t;

  vec_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  wb_arbiter #(.XLEN(32), .REG_AW(5), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_rf_en (pipe_rf_en),
    .pipe_rd    (pipe_rd),
    .pipe_wdata (pipe_wdata),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_wdata  (mdu_wdata),
    .mdu_ready  (mdu_ready),
    .pipe_stall (pipe_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .buf_valid  (buf_valid),
    .buf_rd     (buf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rs, input int pen, input int prd, input int pdat,
                              input int mv, input int mrd, input int mdat,
                              input int e_rdy, input int e_stall, input int e_we,
                              input int e_addr, input int e_data, input int e_bv,
                              input int e_brd);
    vec_t v;
    v.rst_n   = 1'(rs);
    v.pen     = 1'(pen);
    v.prd     = 5'(prd);
    v.pdat    = 32'(pdat);
    v.mv      = 1'(mv);
    v.mrd     = 5'(mrd);
    v.mdat    = 32'(mdat);
    v.e_rdy   = 1'(e_rdy);
    v.e_stall = 1'(e_stall);
    v.e_we    = 1'(e_we);
    v.e_addr  = 5'(e_addr);
    v.e_data  = 32'(e_data);
    v.e_bv    = 1'(e_bv);
    v.e_brd   = 5'(e_brd);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s @%0d: got 0x%0h want 0x%0h", name, idx, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst_n      = v.rst_n;
    pipe_rf_en = v.pen;
    pipe_rd    = v.prd;
    pipe_wdata = v.pdat;
    mdu_valid  = v.mv;
    mdu_rd     = v.mrd;
    mdu_wdata  = v.mdat;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard @%0d: got empty queue want one entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("mdu_ready", idx, 32'(mdu_ready), 32'(e.e_rdy));
      chk("pipe_stall", idx, 32'(pipe_stall), 32'(e.e_stall));
      chk("rf_we", idx, 32'(rf_we), 32'(e.e_we));
      chk("buf_valid", idx, 32'(buf_valid), 32'(e.e_bv));
      if (e.e_we || !e.rst_n) begin
        chk("rf_waddr", idx, 32'(rf_waddr), 32'(e.e_addr));
        chk("rf_wdata", idx, rf_wdata, e.e_data);
      end
      if (e.e_bv) chk("buf_rd", idx, 32'(buf_rd), 32'(e.e_brd));
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    checkOutput(idx);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t tbl[22];
    vec_t v;
    int   rd;

    rst_n      = 1'b0;
    pipe_rf_en = 1'b0;
    pipe_rd    = '0;
    pipe_wdata = '0;
    mdu_valid  = 1'b0;
    mdu_rd     = '0;
    mdu_wdata  = '0;

    // rst, pen, prd, pdat, mv, mrd, mdat | rdy, stall, we, addr, data, bv, brd
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 5, 'hA5, 0, 0, 0,           1, 0, 1, 5, 'hA5, 0, 0);
    tbl[2]  = mk(1, 1, 0, 'h77, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 7, 'h1234,         1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,              0, 0, 1, 7, 'h1234, 1, 7);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 'h55,           1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 9, 'h11, 1, 3, 'hCAFE,      1, 0, 1, 9, 'h11, 0, 0);
    tbl[9]  = mk(1, 1, 3, 'h9, 0, 0, 0,            0, 0, 1, 3, 'h9, 1, 3);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 10, 'h1, 1, 4, 'h44,        1, 0, 1, 10, 'h1, 0, 0);
    tbl[12] = mk(1, 1, 11, 'h2, 0, 0, 0,           0, 0, 1, 11, 'h2, 1, 4);
    tbl[13] = mk(1, 1, 0, 'h3, 0, 0, 0,            0, 0, 1, 4, 'h44, 1, 4);
    tbl[14] = mk(1, 0, 0, 0, 1, 6, 'h66,           1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 8, 'h88, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 1, 12, 'hC, 1, 2, 'h22,        1, 0, 1, 12, 'hC, 0, 0);
    tbl[19] = mk(1, 1, 14, 'hE, 1, 13, 'hDD,       0, 0, 1, 14, 'hE, 1, 2);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,              0, 0, 1, 2, 'h22, 1, 2);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    for (int i = 0; i < 22; i++) runVec(tbl[i], i);

`ifdef WB_ARB_STARVE_GUARD_EN
    $display("[TB] contention with starvation guard");
    runVec(mk(1, 1, 1, 'h100, 1, 7, 'hBEEF, 1, 0, 1, 1, 'h100, 0, 0), 100);
    for (int k = 1; k <= 4; k++) begin
      v = mk(1, 1, 1 + k, 'h100 + k, 0, 0, 0, 0, 0, 1, 1 + k, 'h100 + k, 1, 7);
      runVec(v, 100 + k);
    end
    runVec(mk(1, 1, 6, 'h105, 0, 0, 0, 0, 1, 1, 7, 'hBEEF, 1, 7), 105);
    runVec(mk(1, 1, 6, 'h105, 0, 0, 0, 1, 0, 1, 6, 'h105, 0, 0), 106);
    runVec(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 107);
`else
    $display("[TB] contention without starvation guard");
    runVec(mk(1, 1, 1, 'h200, 1, 7, 'hBEEF, 1, 0, 1, 1, 'h200, 0, 0), 200);
    for (int k = 1; k <= 20; k++) begin
      rd = 8 + (k % 20);
      v  = mk(1, 1, rd, 'h200 + k, 0, 0, 0, 0, 0, 1, rd, 'h200 + k, 1, 7);
      runVec(v, 200 + k);
    end
    runVec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'hBEEF, 1, 7), 221);
    runVec(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 222);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
